// File: rtl/decoder_rr_scheduler_pkg.sv
// Shared definitions for the decoder round-robin scheduler.
//   state_t : FSM state encoding (idle / grant / gap)
//   N_REQ   : number of requesters, one per decoder output line
//   SEL_W   : width of the decoder select bus
package decoder_rr_scheduler_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker for 8 requesters.
//   req     in  8  request vector
//   ptr     in  3  highest-priority index for this pick
//   winner  out 3  first set bit of req scanning ptr, ptr+1, ... modulo 8
//   any_req out 1  at least one request is pending
module rr_pick8
    import decoder_rr_scheduler_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // 3-bit addition wraps index 7 back to 0.
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/decoder_rr_scheduler.sv
// Round-robin scheduler sharing a 3-to-8 decoder between 8 requesters.
// Grants are bounded to MAX_HOLD cycles and always separated by one gap cycle.
//   clk     in  1  system clock, rising edge
//   rst     in  1  asynchronous active-high reset
//   req     in  8  level requests, req[i] for requester i
//   sel     out 3  decoder select {c1,c2,c3}, equals the granted index
//   en      out 1  decoder enable (e3), high only while granting
//   gnt     out 8  one-hot grant, gnt[i] = en & (sel == i)
//   busy    out 1  high while granting or in the gap cycle
//   timeout out 1  one-cycle pulse in the gap after a forced release
module decoder_rr_scheduler
    import decoder_rr_scheduler_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [SEL_W-1:0] winner;
    logic             any_req;

    rr_pick8 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: select, pointer, hold counter, timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle, StGap: begin
                if (any_req) begin
                    state_d = StGrant;
                    sel_d   = winner;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StGrant: begin
                // A dropped request wins over the hold limit: no timeout pulse.
                if (!req[sel_q]) begin
                    state_d = StGap;
                    ptr_d   = sel_q + SEL_W'(1);
                end else if (cnt_q == HoldLast) begin
                    state_d   = StGap;
                    ptr_d     = sel_q + SEL_W'(1);
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs depend on registers only.
    always_comb begin
        sel     = sel_q;
        en      = (state_q == StGrant);
        busy    = (state_q != StIdle);
        timeout = timeout_q;
        gnt     = '0;
        if (state_q == StGrant) begin
            gnt[sel_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Self-checking bench for decoder_rr_scheduler (MAX_HOLD = 4).
module tb_decoder_rr_scheduler;

    localparam int MaxHold = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    decoder_rr_scheduler #(
        .MAX_HOLD (MaxHold),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .sel     (sel),
        .en      (en),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [2:0] sel;
        logic       en;
        logic [7:0] gnt;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t tab[$];

    // Reference model: phase 0 idle, 1 granting, 2 gap.
    int m_phase, m_owner, m_held, m_ptr;
    bit m_to;

    function automatic logic [13:0] pack(logic [2:0] s, logic e, logic [7:0] g, logic b, logic t);
        return {s, e, g, b, t};
    endfunction

    task automatic cmp(input string name, input logic [13:0] exp_v);
        logic [13:0] act;
        act = pack(sel, en, gnt, busy, timeout);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got sel=%0d en=%0b gnt=%h busy=%0b to=%0b, want sel=%0d en=%0b gnt=%h busy=%0b to=%0b",
                     name, act[13:11], act[10], act[9:2], act[1], act[0],
                     exp_v[13:11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic add(input logic [7:0] r, input logic [2:0] s, input logic e,
                       input logic [7:0] g, input logic b, input logic t, input int n);
        vec_t v;
        v.req = r; v.sel = s; v.en = e; v.gnt = g; v.busy = b; v.to = t;
        for (int i = 0; i < n; i++) tab.push_back(v);
    endtask

    task automatic tick(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        cmp("reset_state", pack(3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int pick(logic [7:0] r, int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_to = 0;
    endtask

    // Advance the model by one clock edge with request vector r.
    task automatic model_step(input logic [7:0] r);
        m_to = 0;
        if (m_phase == 1) begin
            if (!r[m_owner] || m_held == MaxHold) begin
                m_to    = r[m_owner];
                m_ptr   = (m_owner + 1) % 8;
                m_phase = 2;
            end else begin
                m_held++;
            end
        end else if (r != 0) begin
            m_owner = pick(r, m_ptr);
            m_held  = 1;
            m_phase = 1;
        end else begin
            m_phase = 0;
        end
    endtask

    function automatic logic [13:0] model_out();
        logic [7:0] g;
        g = 8'h00;
        if (m_phase == 1) g[m_owner] = 1'b1;
        return pack(3'(m_owner), m_phase == 1, g, m_phase != 0, m_to);
    endfunction

    initial begin
        logic [7:0] r;
        int g;

        rst = 1'b1;
        req = 8'h00;

        // Directed table: idle, single request, drop at limit, timeout, wrap.
        add(8'h00, 3'd0, 0, 8'h00, 0, 0, 5);
        add(8'h04, 3'd2, 1, 8'h04, 1, 0, 3);
        add(8'h00, 3'd2, 0, 8'h00, 1, 0, 1);
        add(8'h00, 3'd2, 0, 8'h00, 0, 0, 1);
        add(8'h08, 3'd3, 1, 8'h08, 1, 0, 4);
        add(8'h00, 3'd3, 0, 8'h00, 1, 0, 1);
        add(8'h00, 3'd3, 0, 8'h00, 0, 0, 1);
        add(8'h08, 3'd3, 1, 8'h08, 1, 0, 4);
        add(8'h08, 3'd3, 0, 8'h00, 1, 1, 1);
        add(8'h08, 3'd3, 1, 8'h08, 1, 0, 1);
        add(8'h00, 3'd3, 0, 8'h00, 1, 0, 1);
        add(8'h00, 3'd3, 0, 8'h00, 0, 0, 1);
        add(8'h40, 3'd6, 1, 8'h40, 1, 0, 1);
        add(8'h00, 3'd6, 0, 8'h00, 1, 0, 1);
        add(8'h81, 3'd7, 1, 8'h80, 1, 0, 1);
        add(8'h01, 3'd7, 0, 8'h00, 1, 0, 1);
        add(8'h01, 3'd0, 1, 8'h01, 1, 0, 1);
        add(8'h00, 3'd0, 0, 8'h00, 1, 0, 1);
        add(8'h00, 3'd0, 0, 8'h00, 0, 0, 1);

        do_reset();
        foreach (tab[i]) begin
            tick(tab[i].req);
            cmp($sformatf("table[%0d]", i),
                pack(tab[i].sel, tab[i].en, tab[i].gnt, tab[i].busy, tab[i].to));
        end

        // Fairness with all requesting: 4 grant cycles then 1 gap, in index order.
        do_reset();
        for (int t = 0; t < 45; t++) begin
            tick(8'hFF);
            g = (t / 5) % 8;
            if (t % 5 < 4) begin
                cmp($sformatf("fair[%0d]", t), pack(3'(g), 1'b1, 8'h01 << g, 1'b1, 1'b0));
            end else begin
                cmp($sformatf("fair[%0d]", t), pack(3'(g), 1'b0, 8'h00, 1'b1, 1'b1));
            end
        end

        // Asynchronous reset in the middle of a grant to index 5.
        do_reset();
        tick(8'h20);
        cmp("pre_async", pack(3'd5, 1'b1, 8'h20, 1'b1, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        cmp("async_rst", pack(3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        tick(8'h21);
        cmp("post_rst_ptr0", pack(3'd0, 1'b1, 8'h01, 1'b1, 1'b0));

        // Randomised stimulus against the reference model.
        do_reset();
        model_reset();
        r = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    r = 8'h00;
                2, 3:    r = 8'h01 << $urandom_range(0, 7);
                4:       r = 8'($urandom);
                5:       r = r ^ (8'h01 << $urandom_range(0, 7));
                default: r = r;
            endcase
            tick(r);
            model_step(r);
            cmp($sformatf("rand[%0d]", n), model_out());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_rr_scheduler.md
Name: decoder_rr_scheduler

Overview:
Round-robin scheduler that shares the 3-to-8 decoder's output lines between 8 requesters. It drives the decoder select inputs (c1..c3) and its active-high enable (e3), and enforces a bounded hold time per grant. It inserts a one-cycle gap between grants so two decoder lines are never selected back to back. It sits between the requesting logic and the decoder instance, with e1_low and e2_low tied to 0 at the parent level.

Parameters:
MAX_HOLD, 16, maximum consecutive GRANT cycles per grant; legal range 2..255.
CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  8  level requests; req[i] is requester i, index 0 maps to decoder output d1
sel  output 3  decoder select {c1,c2,c3}; c1 is the MSB; equals the granted index
en   output 1  decoder enable, drives e3; high only in GRANT
gnt  output 8  one-hot grant, gnt[i] = en & (sel==i)
busy output 1  high in GRANT and GAP
timeout output 1  one-cycle pulse when a grant is force-released at MAX_HOLD

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, sel=0, en=0, gnt=0, busy=0, timeout=0, pointer ptr=0, hold counter=0. Deasserting rst takes effect at the next clk edge.
- All outputs are registered. Latency from req asserted to gnt is 1 cycle from IDLE.
- States:
  - IDLE: if req!=0, pick the winner, load sel=winner, clear the counter, go to GRANT. Otherwise stay.
  - GRANT: en=1, counter increments each cycle.
    - If req[sel]==0: release, go to GAP.
    - Else if counter==MAX_HOLD-1: release, pulse timeout for that cycle's successor (the first GAP cycle), go to GAP.
  - GAP: exactly 1 cycle, en=0, sel holds the last value. Then:
    - if req!=0, pick a winner and go to GRANT (back-to-back grants are separated by exactly one GAP cycle);
    - else go to IDLE.
- Winner selection: the first set bit of req scanning ptr, ptr+1, ..., ptr+7 modulo 8.
- On every release, ptr = last granted index + 1, mod 8. Index 7 wraps to 0. This applies to both normal release and timeout.
- A timed-out requester that keeps req high becomes lowest priority. It is re-granted only when no other request is pending, after the GAP.
- req changes on non-granted lines during GRANT do not affect the current grant.
- Simultaneous events:
  - The granted req drops on the same cycle the counter reaches MAX_HOLD-1: treat as a normal release; timeout is NOT pulsed.
- rst mid-GRANT: outputs clear asynchronously and en drops immediately. ptr returns to 0.
- When en=0, the decoder drives all ones. Consumers must qualify decoder outputs with en, or use gnt.
- sel width is fixed at 3 and the request count is fixed at 8, matching the decoder.

Decomposition:
- Shared package (or a `include header): state encodings IDLE=2'd0, GRANT=2'd1, GAP=2'd2; constant N_REQ=8; SEL_W=3.
- One sub-module is natural: rr_pick8. It is combinational and takes req[7:0] and ptr[2:0], and returns winner[2:0] and any_req. It is instantiated once.
- The FSM, counter and pointer live in the top module.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> state IDLE, en=0, gnt=0, sel=0, busy=0.
- req=8'b0000_0100 held for 3 cycles, then dropped -> one cycle later gnt=8'h04, sel=3'd2, en=1. After the drop, one GAP cycle (en=0, busy=1), then IDLE.
- Fairness: req=8'hFF held constant, MAX_HOLD=4 -> grant order 0,1,2,...,7,0. Each grant is exactly 4 cycles followed by 1 GAP. timeout pulses once per grant.
- Wrap and priority: ptr=7 after serving index 6, req=8'b1000_0001 -> index 7 granted first, then index 0.
- Simultaneous drop at the limit: req[3] deasserted on the cycle the counter reaches MAX_HOLD-1 -> release to GAP, timeout stays 0.
- Asynchronous reset mid-GRANT (sel=5) -> en, gnt and busy go to 0 before the next clk edge. After reset, req=8'h21 grants index 0 first, because ptr was reset to 0.
